// File: rtl/data_memory_sized.sv
// Byte-addressable data memory with RISC-V sub-word loads/stores, configurable
// access latency, a ready handshake for the stall logic and a fault pulse.
module data_memory_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] Write_data,
  output logic [31:0] MemData_out,
  output logic        mem_ready,
  output logic        mem_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            accept;
  logic            complete;

  logic            req_write;
  logic [2:0]      req_f3;
  logic [AW+1:0]   req_addr;
  logic [31:0]     req_data;
  logic            req_fault;

  logic [31:0]     mem_reg [DEPTH_WORDS];
  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_value;
  logic [3:0]      byte_en;
  logic [31:0]     store_data;

  // Address bits above the memory span are ignored, so accesses wrap.
  logic [31-AW-2:0] unused_addr_bits;
  assign unused_addr_bits = read_address[31:AW+2];

  assign accept    = (state_reg == IDLE) && (MemRead || MemWrite);
  assign mem_ready = (state_reg == IDLE);

  generate
    if (LATENCY == 0) begin : g_direct
      assign req_write = MemWrite;
      assign req_f3    = funct3;
      assign req_addr  = read_address[AW+1:0];
      assign req_data  = Write_data;
      assign complete  = accept;
    end else begin : g_captured
      logic          write_reg;
      logic [2:0]    f3_reg;
      logic [AW+1:0] addr_reg;
      logic [31:0]   data_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          write_reg <= 1'b0;
          f3_reg    <= '0;
          addr_reg  <= '0;
          data_reg  <= '0;
        end else if (accept) begin
          write_reg <= MemWrite;
          f3_reg    <= funct3;
          addr_reg  <= read_address[AW+1:0];
          data_reg  <= Write_data;
        end
      end

      assign req_write = write_reg;
      assign req_f3    = f3_reg;
      assign req_addr  = addr_reg;
      assign req_data  = data_reg;
      assign complete  = (state_reg == BUSY) && (count_reg == CW'(1));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (LATENCY > 0)) begin
          state_next = BUSY;
          count_next = CW'(LATENCY);
        end
      end
      BUSY: begin
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign word_idx = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem_reg[word_idx];
  assign sel_byte = rd_word[{lane, 3'b000} +: 8];
  assign sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // BU/HU encodings are legal only as loads; every store outside B/H/W faults.
  always_comb begin
    req_fault = 1'b0;
    case (req_f3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = lane[0];
      3'b010:  req_fault = (lane != 2'b00);
      3'b100:  req_fault = req_write;
      3'b101:  req_fault = req_write || lane[0];
      default: req_fault = 1'b1;
    endcase
  end

  always_comb begin
    load_value = rd_word;
    case (req_f3)
      3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_value = {24'h0, sel_byte};
      3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_value = {16'h0, sel_half};
      default: load_value = rd_word;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        byte_en[gi]          = 1'b1;
        store_data[8*gi +: 8] = req_data[8*gi +: 8];
        if (req_f3 == 3'b000) begin
          byte_en[gi]           = (lane == 2'(gi));
          store_data[8*gi +: 8] = req_data[7:0];
        end else if (req_f3 == 3'b001) begin
          byte_en[gi]           = (lane[1] == (gi >= 2));
          store_data[8*gi +: 8] = req_data[8*(gi%2) +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_reg[i] <= '0;
    end else if (complete && req_write && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_reg[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemData_out <= '0;
      mem_fault   <= 1'b0;
    end else begin
      mem_fault <= complete && req_fault;
      if (complete && !req_write && !req_fault) MemData_out <= load_value;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: three instances with LATENCY 1, 3 and 0.
module tb_data_memory_sized;

  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 3, 0};

  logic        clk;
  logic        rst   [NI];
  logic        mrd   [NI];
  logic        mwr   [NI];
  logic [2:0]  f3    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] dout  [NI];
  logic        rdy   [NI];
  logic        flt   [NI];
  logic [31:0] last_load [NI];

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  data_memory_sized #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(rst[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .funct3(f3[0]),
    .read_address(addr[0]), .Write_data(wdata[0]), .MemData_out(dout[0]),
    .mem_ready(rdy[0]), .mem_fault(flt[0]));

  data_memory_sized #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(rst[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .funct3(f3[1]),
    .read_address(addr[1]), .Write_data(wdata[1]), .MemData_out(dout[1]),
    .mem_ready(rdy[1]), .mem_fault(flt[1]));

  data_memory_sized #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(rst[2]), .MemRead(mrd[2]), .MemWrite(mwr[2]), .funct3(f3[2]),
    .read_address(addr[2]), .Write_data(wdata[2]), .MemData_out(dout[2]),
    .mem_ready(rdy[2]), .mem_fault(flt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs(input int k);
    mrd[k]   = 1'b0;
    mwr[k]   = 1'b0;
    f3[k]    = 3'b000;
    addr[k]  = 32'h0;
    wdata[k] = 32'h0;
  endtask

  // op: 0 load, 1 store, 2 both strobes (store). Expected load data is only
  // used for non-faulting loads; otherwise the previous load result must hold.
  task automatic access(input int k, input int op, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_load, input logic exp_fault,
                        input bit intrude, input string name);
    exp_t e;
    exp_t got;
    int   busy;
    e.fault = exp_fault;
    e.data  = (op == 0 && !exp_fault) ? exp_load : last_load[k];
    e.lat   = LAT[k];
    sb_q.push_back(e);
    last_load[k] = e.data;

    @(negedge clk);
    mrd[k]   = (op != 1);
    mwr[k]   = (op != 0);
    f3[k]    = fn;
    addr[k]  = a;
    wdata[k] = d;
    @(posedge clk);
    @(negedge clk);
    if (intrude) begin
      mrd[k]   = 1'b0;
      mwr[k]   = 1'b1;
      f3[k]    = 3'b010;
      addr[k]  = 32'h20;
      wdata[k] = 32'hDEADBEEF;
    end else begin
      idle_inputs(k);
    end
    busy = 0;
    while (rdy[k] !== 1'b1 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    idle_inputs(k);
    got = sb_q.pop_front();

    n_cmp++;
    if (busy !== got.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d busy cycles, expected %0d", name, busy, got.lat);
    end
    n_cmp++;
    if (dout[k] !== got.data) begin
      n_err++;
      $display("FAIL %s data: got %h, expected %h", name, dout[k], got.data);
    end
    n_cmp++;
    if (flt[k] !== got.fault) begin
      n_err++;
      $display("FAIL %s fault: got %b, expected %b", name, flt[k], got.fault);
    end
    @(negedge clk);
    n_cmp++;
    if (flt[k] !== 1'b0) begin
      n_err++;
      $display("FAIL %s fault_pulse: got %b one cycle later, expected 0", name, flt[k]);
    end
    $display("inst %0d %-14s addr=%h wdata=%h dout=%h fault=%b busy=%0d",
             k, name, a, d, dout[k], got.fault, busy);
  endtask

  task automatic test_reset;
    for (int k = 0; k < NI; k++) begin
      idle_inputs(k);
      rst[k] = 1'b1;
      last_load[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp += 3;
      if (dout[k] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_dout inst %0d: got %h, expected 00000000", k, dout[k]);
      end
      if (rdy[k] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready inst %0d: got %b, expected 1", k, rdy[k]);
      end
      if (flt[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_fault inst %0d: got %b, expected 0", k, flt[k]);
      end
      $display("inst %0d reset         dout=%h ready=%b fault=%b", k, dout[k], rdy[k], flt[k]);
    end
  endtask

  task automatic test_first_load;
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0, "lw_after_reset");
  endtask

  task automatic test_subword;
    access(0, 1, 3'b010, 32'h14, 32'hABCD1234, 32'h0, 1'b0, 1'b0, "sw_14");
    access(0, 0, 3'b010, 32'h14, 32'h0, 32'hABCD1234, 1'b0, 1'b0, "lw_14");
    access(0, 0, 3'b000, 32'h17, 32'h0, 32'hFFFFFFAB, 1'b0, 1'b0, "lb_17");
    access(0, 0, 3'b100, 32'h17, 32'h0, 32'h000000AB, 1'b0, 1'b0, "lbu_17");
    access(0, 0, 3'b001, 32'h14, 32'h0, 32'h00001234, 1'b0, 1'b0, "lh_14");
    access(0, 0, 3'b101, 32'h16, 32'h0, 32'h0000ABCD, 1'b0, 1'b0, "lhu_16");
  endtask

  task automatic test_partial_store;
    access(0, 1, 3'b000, 32'h15, 32'h000000EE, 32'h0, 1'b0, 1'b0, "sb_15");
    access(0, 0, 3'b010, 32'h14, 32'h0, 32'hABCDEE34, 1'b0, 1'b0, "lw_14_sb");
    access(0, 0, 3'b000, 32'h15, 32'h0, 32'hFFFFFFEE, 1'b0, 1'b0, "lb_15");
    access(0, 1, 3'b001, 32'h16, 32'h00008001, 32'h0, 1'b0, 1'b0, "sh_16");
    access(0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, "lh_16");
    access(0, 0, 3'b010, 32'h14, 32'h0, 32'h8001EE34, 1'b0, 1'b0, "lw_14_sh");
  endtask

  task automatic test_faults;
    access(0, 0, 3'b010, 32'h16, 32'h0, 32'h0, 1'b1, 1'b0, "lw_misalign");
    access(0, 1, 3'b001, 32'h15, 32'h00001111, 32'h0, 1'b1, 1'b0, "sh_misalign");
    access(0, 0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1'b0, "ld_f3_011");
    access(0, 1, 3'b100, 32'h14, 32'h00000077, 32'h0, 1'b1, 1'b0, "st_f3_100");
    access(0, 0, 3'b001, 32'h15, 32'h0, 32'h0, 1'b1, 1'b0, "lh_misalign");
    access(0, 0, 3'b010, 32'h14, 32'h0, 32'h8001EE34, 1'b0, 1'b0, "lw_14_intact");
  endtask

  task automatic test_latency3;
    access(1, 1, 3'b010, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b1, "sw_busy_req");
    access(1, 0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, 1'b0, "lw_ignored");
    access(1, 0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0, "lw_10_l3");
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    mwr[1]   = 1'b1;
    f3[1]    = 3'b010;
    addr[1]  = 32'h8;
    wdata[1] = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    idle_inputs(1);
    n_cmp++;
    if (rdy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL busy_before_reset: ready got %b, expected 0", rdy[1]);
    end
    rst[1] = 1'b1;
    #1;
    n_cmp += 2;
    if (rdy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL ready_on_reset: got %b, expected 1", rdy[1]);
    end
    if (dout[1] !== 32'h0) begin
      n_err++;
      $display("FAIL dout_on_reset: got %h, expected 00000000", dout[1]);
    end
    $display("inst 1 reset_in_busy  ready=%b dout=%h", rdy[1], dout[1]);
    @(negedge clk);
    rst[1] = 1'b0;
    last_load[1] = 32'h0;
    access(1, 0, 3'b010, 32'h8, 32'h0, 32'h00000000, 1'b0, 1'b0, "lw_8_aborted");
  endtask

  task automatic test_wrap;
    access(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "sw_400");
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, "lw_0_wrap");
    access(0, 2, 3'b010, 32'h8, 32'h0BADC0DE, 32'h0, 1'b0, 1'b0, "rw_both_8");
    access(0, 0, 3'b010, 32'h8, 32'h0, 32'h0BADC0DE, 1'b0, 1'b0, "lw_8_both");
  endtask

  task automatic test_back_to_back;
    access(2, 1, 3'b010, 32'h0, 32'h11223344, 32'h0, 1'b0, 1'b0, "l0_sw_0");
    access(2, 0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0, 1'b0, "l0_lw_0");
    access(2, 0, 3'b101, 32'h2, 32'h0, 32'h00001122, 1'b0, 1'b0, "l0_lhu_2");
    access(2, 0, 3'b000, 32'h1, 32'h0, 32'h00000033, 1'b0, 1'b0, "l0_lb_1");
    access(2, 0, 3'b010, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0, "l0_lw_misalign");
    access(2, 1, 3'b000, 32'h3, 32'h00000099, 32'h0, 1'b0, 1'b0, "l0_sb_3");
    access(2, 0, 3'b010, 32'h0, 32'h0, 32'h99223344, 1'b0, 1'b0, "l0_lw_0_sb");
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_subword();
    test_partial_store();
    test_faults();
    test_latency3();
    test_reset_busy();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Parametrised successor to the single-cycle word data memory in the writeback cycle. Adds RISC-V sub-word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3, a configurable access latency, a ready handshake toward the pipeline stall logic, and a fault flag for misaligned or illegal accesses. Sits between the EX/MEM pipeline register and the writeback mux.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
LATENCY, 1, wait cycles after the accept edge before completion; 0 means the access completes on the accept edge.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state and memory contents
MemRead  input  1  read request
MemWrite  input  1  write request; wins over MemRead if both are high
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
read_address  input  32  byte address for loads and stores
Write_data  input  32  store data; the low byte or halfword is used for SB/SH
MemData_out  output  32  formatted load result; registered
mem_ready  output  1  1 = idle and able to accept a request; 0 = busy (pipeline stalls)
mem_fault  output  1  one-cycle pulse on completion of a faulting access

Behaviour:
- Reset: MemData_out=0, mem_ready=1, mem_fault=0, state=IDLE, counter=0, every memory word=0. Reset mid-access aborts it; a pending write is not committed.
- Word index = read_address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- FSM states: IDLE and BUSY.
- IDLE: mem_ready=1. A rising edge with MemRead or MemWrite high is the accept edge. The block captures the operation, funct3, address and data on that edge.
  - LATENCY=0: the access completes on the accept edge and the FSM stays in IDLE.
  - LATENCY>0: go to BUSY with counter=LATENCY; mem_ready=0 from the next cycle.
- BUSY: counter decrements on every edge. On the edge where counter=1, the access completes, the FSM returns to IDLE and mem_ready=1. Requests presented during BUSY are ignored, not queued.
- Completion is exactly LATENCY edges after the accept edge.
- Fault conditions, checked on the captured request:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- Faulting access: memory unchanged, MemData_out unchanged, mem_fault=1 for exactly one cycle after the completion edge.
- Store completion:
  - SB writes byte lane addr[1:0] with Write_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with Write_data[15:0].
  - SW writes the full word.
  - Other lanes are preserved.
  - MemData_out is unchanged.
- Load completion: MemData_out is updated on the completion edge.
  - B: sign-extend the selected byte; BU: zero-extend it.
  - H: sign-extend the selected halfword; HU: zero-extend it.
  - W: the full word.
- Data ordering is little-endian: byte lane 0 = bits [7:0].
- MemData_out holds the last successful load value until the next successful load.
- If MemRead and MemWrite are both high at accept, the access is a store.
- Read-after-write: a load accepted after a store completes sees the stored data.

Test Plan:
- Reset then LW at 0x0 with LATENCY=1 -> mem_ready low for 1 cycle, MemData_out=0x00000000, mem_fault=0.
- SW 0xABCD1234 at 0x14, then LW at 0x14 -> MemData_out=0xABCD1234. Then LB at 0x17 -> 0xFFFFFFAB, LBU at 0x17 -> 0x000000AB, LH at 0x14 -> 0x00001234, LHU at 0x16 -> 0x0000ABCD.
- SB 0x000000EE at 0x15, then LW at 0x14 -> 0xABCDEE34 (other lanes preserved). SH 0x8001 at 0x16, then LH at 0x16 -> 0xFFFF8001.
- LW at 0x16 and SH at 0x15 -> mem_fault pulses one cycle each; memory and MemData_out unchanged. Load funct3=011 -> fault.
- LATENCY=3: a second request held high during BUSY is ignored; completion occurs 3 edges after accept. Assert reset during BUSY of an SW 0x55 at 0x8 -> a subsequent LW at 0x8 returns 0; mem_ready=1 immediately on reset.
- DEPTH_WORDS=256: SW at 0x400 then LW at 0x0 -> same word (wrap-around). MemRead=MemWrite=1 performs a store.
